// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, cell codes and cell type for the maze display.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_CELLS = FB_W * FB_H;

  typedef logic [2:0] cell_t;

  localparam cell_t CELL_EMPTY  = 3'd0;
  localparam cell_t CELL_WALL   = 3'd1;
  localparam cell_t CELL_PELLET = 3'd2;
  localparam cell_t CELL_PACMAN = 3'd3;

endpackage

// File: rtl/fb_wr_fifo.sv
// Posted-write FIFO holding {addr,data} entries destined for the framebuffer.
// Latency: an entry pushed in a cycle is visible at the head from the next cycle.
// Backpressure: push is ignored when full, pop when empty; no same-cycle bypass.
module fb_wr_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = store[rd_ptr];

  // Entry storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_cell_arbiter.sv
// Shares the single-port cell framebuffer between the VGA fetch and NUM_WR writers (stats: FB_ARB_STATS_EN).
// Latency: display read data valid 2 cycles after disp_req; posted writes reach RAM >= 1 cycle after ack.
// Backpressure: display never stalls; writers hold req until wr_ack, withheld while the FIFO is full.
module fb_cell_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_WR = 2,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3,
  parameter int CELLS  = FB_CELLS,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     disp_req,
  input  logic [ADDR_W-1:0]        disp_addr,
  output logic [DATA_W-1:0]        disp_data,
  output logic                     disp_valid,
  input  logic [NUM_WR-1:0]        wr_req,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [NUM_WR-1:0]        wr_ack,
  output logic                     wr_idle,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
`ifdef FB_ARB_STATS_EN
  input  logic                     stat_clr,
  output logic [15:0]              stat_drop,
  output logic [15:0]              stat_full,
`endif
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int RR_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] CELLS_LIM = (ADDR_W+1)'(CELLS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } wr_ent_t;

  logic [RR_W-1:0]  rr_ptr;
  logic [RR_W-1:0]  gnt_idx;
  logic             gnt_vld;
  logic             accept;
  logic             in_range;
  logic             do_push;
  logic             do_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  wr_ent_t          gnt_ent;
  wr_ent_t          head_ent;
  logic [1:0]       vld_sr;

  // Round-robin search: the lowest offset from rr_ptr with a request wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      if (wr_req[(int'(rr_ptr) + k) % NUM_WR]) begin
        gnt_vld = 1'b1;
        gnt_idx = RR_W'((int'(rr_ptr) + k) % NUM_WR);
      end
    end
  end

  assign gnt_ent.addr = wr_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign gnt_ent.dat  = wr_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign in_range     = ({1'b0, gnt_ent.addr} < CELLS_LIM);

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign accept  = gnt_vld && !fifo_full && !reset;
  assign do_push = accept && in_range;
  assign do_pop  = !disp_req && !fifo_empty;

  // One-hot acknowledge for the granted writer; out-of-range writes are acked but discarded.
  always_comb begin
    wr_ack = '0;
    if (accept) wr_ack[gnt_idx] = 1'b1;
  end

  fb_wr_fifo #(
    .W     ($bits(wr_ent_t)),
    .DEPTH (DEPTH)
  ) u_wr_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (do_push),
    .push_dat (gnt_ent),
    .pop      (do_pop),
    .head_dat (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  // Advance the round-robin pointer past the writer just accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(gnt_idx) == NUM_WR - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // RAM port slot: display read first, otherwise drain one posted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (disp_req) begin
      mem_addr <= disp_addr;
      mem_we   <= 1'b0;
    end else if (!fifo_empty) begin
      mem_addr  <= head_ent.addr;
      mem_wdata <= head_ent.dat;
      mem_we    <= 1'b1;
    end else begin
      mem_we <= 1'b0;
    end
  end

  // Two-stage valid pipe matching address register plus RAM read register.
  always_ff @(posedge clk) begin
    if (reset) vld_sr <= '0;
    else       vld_sr <= {vld_sr[0], disp_req};
  end

  assign disp_valid = vld_sr[1];
  assign disp_data  = mem_rdata;
  assign wr_idle    = (fifo_cnt == '0) && !mem_we;

`ifdef FB_ARB_STATS_EN
  logic full_hit;
  assign full_hit = fifo_full && (|wr_req);

  // Saturating drop and full-stall counters.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_drop <= '0;
      stat_full <= '0;
    end else begin
      if (accept && !in_range && stat_drop != 16'hFFFF) stat_drop <= stat_drop + 1'b1;
      if (full_hit && stat_full != 16'hFFFF)            stat_full <= stat_full + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_cell_arbiter.sv
// Bench for fb_cell_arbiter: vector table, directed corner sequences, random traffic vs a queue model.
// Latency: checks display data 2 cycles after request and write drain order.
// Backpressure: writers hold requests until acknowledged.
module tb_fb_cell_arbiter;
  import fb_pkg::*;

  localparam int NUM_WR = 2;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 4;
  localparam int CELLS  = 19200;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     disp_req;
  logic [ADDR_W-1:0]        disp_addr;
  logic [DATA_W-1:0]        disp_data;
  logic                     disp_valid;
  logic [NUM_WR-1:0]        wr_req;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        wr_ack;
  logic                     wr_idle;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_we;
  logic [DATA_W-1:0]        mem_rdata;
`ifdef FB_ARB_STATS_EN
  logic                     stat_clr = 1'b0;
  logic [15:0]              stat_drop;
  logic [15:0]              stat_full;
`endif

  always #5 clk = ~clk;

  fb_cell_arbiter #(
    .NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELLS(CELLS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_idle(wr_idle),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
`ifdef FB_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_drop(stat_drop), .stat_full(stat_full),
`endif
    .mem_rdata(mem_rdata)
  );

  function automatic logic [2:0] init_val(input int a);
    return (a == 5) ? CELL_WALL : 3'((a * 5 + 3) % 8);
  endfunction

  // Framebuffer RAM with registered read; loads its image on the first edge (DUT is in reset then).
  logic [2:0] ram [0:32767];
  bit         ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32768; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  typedef struct { int addr; int dat; } ent_t;
  typedef struct { bit disp; bit [1:0] req; int a0; int a1; bit [1:0] ack; bit idle; } vec_t;

  // Reference model state: posted-write queue, expected RAM image, expected port registers.
  ent_t       mq[$];
  ent_t       pend0[$];
  ent_t       pend1[$];
  logic [2:0] mram [0:32767];
  int         rr;
  bit         exp_we;
  int         exp_addr, exp_wd;
  bit         v0, v1;
  int         d0, d1;
  bit         disp;
  int         daddr;
  bit         chk_en;
  logic [1:0] last_ack;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check against the model before the edge, then advance the model.
  task automatic step(input bit rst);
    int g;
    bit acc;
    ent_t e, e2;
    reset     = rst;
    disp_req  = disp;
    disp_addr = ADDR_W'(daddr);
    wr_req    = '0;
    wr_addr   = '0;
    wr_data   = '0;
    if (pend0.size() > 0) begin
      wr_req[0] = 1'b1;
      wr_addr[0 +: ADDR_W] = ADDR_W'(pend0[0].addr);
      wr_data[0 +: DATA_W] = DATA_W'(pend0[0].dat);
    end
    if (pend1.size() > 0) begin
      wr_req[1] = 1'b1;
      wr_addr[ADDR_W +: ADDR_W] = ADDR_W'(pend1[0].addr);
      wr_data[DATA_W +: DATA_W] = DATA_W'(pend1[0].dat);
    end
    @(negedge clk);
    g = -1;
    if (!rst && mq.size() < DEPTH) begin
      for (int k = 0; k < NUM_WR; k++) begin
        int i;
        i = (rr + k) % NUM_WR;
        if (g < 0 && wr_req[i]) g = i;
      end
    end
    acc = (g >= 0);
    last_ack = wr_ack;
    if (chk_en) begin
      check("wr_ack", wr_ack, acc ? (1 << g) : 0);
      check("disp_valid", disp_valid, v1);
      if (v1) check("disp_data", disp_data, d1);
      check("mem_we", mem_we, exp_we);
      check("mem_addr", mem_addr, exp_addr);
      if (exp_we) check("mem_wdata", mem_wdata, exp_wd);
      check("wr_idle", wr_idle, (mq.size() == 0) && !exp_we);
    end
    @(posedge clk);
    if (exp_we) mram[exp_addr] = 3'(exp_wd);
    if (acc) e = (g == 0) ? pend0.pop_front() : pend1.pop_front();
    if (rst) begin
      mq.delete();
      exp_we = 0; exp_addr = 0; exp_wd = 0; rr = 0; v0 = 0; v1 = 0;
    end else begin
      v1 = v0; d1 = d0;
      v0 = disp; d0 = int'(mram[daddr]);
      if (disp) begin
        exp_addr = daddr; exp_we = 0;
      end else if (mq.size() > 0) begin
        e2 = mq.pop_front();
        exp_addr = e2.addr; exp_wd = e2.dat; exp_we = 1;
      end else begin
        exp_we = 0;
      end
      if (acc) begin
        rr = (g + 1) % NUM_WR;
        if (e.addr < CELLS) mq.push_back(e);
      end
    end
    #1;
  endtask

  vec_t tbl[8];
  int   acks, nwe, burst, bad_cells;

  initial begin
    tbl[0] = '{0, 2'b00, 0,     0,     2'b00, 1};
    tbl[1] = '{0, 2'b01, 100,   0,     2'b01, 0};
    tbl[2] = '{0, 2'b10, 0,     200,   2'b10, 0};
    tbl[3] = '{0, 2'b11, 100,   200,   2'b01, 0};
    tbl[4] = '{0, 2'b01, 19200, 0,     2'b01, 1};
    tbl[5] = '{1, 2'b10, 0,     300,   2'b10, 0};
    tbl[6] = '{1, 2'b01, 32767, 0,     2'b01, 1};
    tbl[7] = '{0, 2'b10, 0,     19199, 2'b10, 0};

    for (int i = 0; i < 32768; i++) mram[i] = init_val(i);
    rr = 0; exp_we = 0; exp_addr = 0; exp_wd = 0; v0 = 0; v1 = 0; d0 = 0; d1 = 0;
    disp = 0; daddr = 0; chk_en = 0;

    // Reset state.
    step(1);
    chk_en = 1;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_wr_idle", wr_idle, 1);
    check("rst_wr_ack", wr_ack, 0);

    // Single-cycle acceptance vectors, each from a fresh reset.
    foreach (tbl[v]) begin
      pend0.delete(); pend1.delete();
      disp = 0;
      step(1);
      disp = tbl[v].disp; daddr = 3;
      if (tbl[v].req[0]) pend0.push_back('{tbl[v].a0, 1});
      if (tbl[v].req[1]) pend1.push_back('{tbl[v].a1, 2});
      step(0);
      check("vec_ack", last_ack, tbl[v].ack);
      check("vec_idle", wr_idle, tbl[v].idle);
      check("vec_we", mem_we, 0);
    end
    pend0.delete(); pend1.delete();
    disp = 0;
    step(1);

    // Display read of a wall cell: address next cycle, data two cycles later.
    disp = 1; daddr = 5;
    step(0);
    check("rd_mem_addr", mem_addr, 5);
    check("rd_idle", wr_idle, 1);
    disp = 0;
    step(0);
    check("rd_valid", disp_valid, 1);
    check("rd_data", disp_data, 1);
    step(0);
    check("rd_valid_drop", disp_valid, 0);

    // Two writers at once: writer 0 first, then writer 1, each drained a cycle after its push.
    pend0.push_back('{100, 2});
    pend1.push_back('{200, 3});
    step(0);
    check("two_ack0", last_ack, 2'b01);
    check("two_we0", mem_we, 0);
    step(0);
    check("two_ack1", last_ack, 2'b10);
    check("two_we1", mem_we, 1);
    check("two_addr1", mem_addr, 100);
    check("two_data1", mem_wdata, 2);
    step(0);
    check("two_we2", mem_we, 1);
    check("two_addr2", mem_addr, 200);
    check("two_data2", mem_wdata, 3);
    step(0);
    check("two_we3", mem_we, 0);
    check("two_idle", wr_idle, 1);

    // Display hogs the port: FIFO fills at DEPTH, then drains in order once released.
    disp = 1; daddr = 7;
    for (int i = 0; i < 6; i++) pend0.push_back('{1000 + i, i % 8});
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      step(0);
      if (last_ack[0]) acks++;
    end
    check("full_acks", acks, DEPTH);
    check("full_no_ack", last_ack, 0);
    disp = 0; nwe = 0;
    for (int c = 0; c < 40; c++) begin
      step(0);
      if (last_ack[0]) acks++;
      if (mem_we) nwe++;
      if (pend0.size() == 0 && wr_idle) break;
    end
    check("full_total_acks", acks, 6);
    check("full_ram_writes", nwe, 6);

    // Out-of-range write: acknowledged, never reaches RAM.
    step(1);
    pend0.push_back('{19200, 1});
    step(0);
    check("oor_ack", last_ack, 2'b01);
    for (int c = 0; c < 3; c++) begin
      step(0);
      check("oor_no_we", mem_we, 0);
      check("oor_idle", wr_idle, 1);
    end
`ifdef FB_ARB_STATS_EN
    check("stat_drop", stat_drop, 1);
`endif

    // Reset with three queued writes discards them.
    disp = 1; daddr = 9;
    for (int i = 0; i < 3; i++) pend0.push_back('{2000 + i, 5});
    for (int c = 0; c < 3; c++) step(0);
    check("q3_not_idle", wr_idle, 0);
    disp = 0;
    step(1);
    check("q3_rst_we", mem_we, 0);
    check("q3_rst_idle", wr_idle, 1);
    nwe = 0;
    for (int c = 0; c < 4; c++) begin
      step(0);
      if (mem_we) nwe++;
    end
    check("q3_no_writes", nwe, 0);

    // Round robin under continuous requests from both writers.
    for (int i = 0; i < 4; i++) begin
      pend0.push_back('{3000 + i, 2});
      pend1.push_back('{4000 + i, 4});
    end
    for (int c = 0; c < 4; c++) begin
      step(0);
      check("rr_ack", last_ack, (c % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Random traffic against the model.
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (burst > 0) begin
        burst--; disp = 1;
      end else begin
        disp = ($urandom_range(0, 99) < 40);
        if ($urandom_range(0, 99) < 3) burst = $urandom_range(5, 25);
      end
      daddr = $urandom_range(0, CELLS - 1);
      if (pend0.size() == 0 && $urandom_range(0, 99) < 50)
        pend0.push_back('{($urandom_range(0, 9) == 0) ? $urandom_range(CELLS, 32767) : $urandom_range(0, CELLS - 1),
                          $urandom_range(0, 7)});
      if (pend1.size() == 0 && $urandom_range(0, 99) < 50)
        pend1.push_back('{($urandom_range(0, 9) == 0) ? $urandom_range(CELLS, 32767) : $urandom_range(0, CELLS - 1),
                          $urandom_range(0, 7)});
      step($urandom_range(0, 999) == 0);
    end

    // Drain and compare the whole RAM image.
    disp = 0;
    for (int c = 0; c < 60; c++) begin
      step(0);
      if (pend0.size() == 0 && pend1.size() == 0 && wr_idle) break;
    end
    check("drain_idle", wr_idle, 1);
    bad_cells = 0;
    for (int i = 0; i < CELLS; i++) if (ram[i] !== mram[i]) bad_cells++;
    check("ram_image", bad_cells, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
